alu_mc: RTL

ALU_MC -- requirements
Module: alu_mc

---
 rtl/alu_mc_pkg.sv | 29 ++
 rtl/alu_mc_if.sv | 30 +++
 rtl/alu_mc_shift.sv | 36 +++
 rtl/alu_mc.sv | 159 +++++++++++++++
 4 files changed

// File: rtl/alu_mc_pkg.sv
// Shared encodings for the multi-cycle ALU: unit selects, FSM states, flag bit positions.
// Latency: n/a (types and constants only).
// Backpressure: n/a.
package alu_mc_pkg;

    typedef enum logic [2:0] {
        UNIT_ADD      = 3'b000,
        UNIT_MUL      = 3'b001,
        UNIT_SHIFT    = 3'b010,
        UNIT_PASS_SRC = 3'b011,
        UNIT_OR       = 3'b100,
        UNIT_XOR      = 3'b101,
        UNIT_AND      = 3'b110,
        UNIT_PASS_ACC = 3'b111
    } unit_e;

    typedef enum logic [1:0] {
        ST_IDLE,
        ST_BUSY,
        ST_DONE
    } state_e;

    // flags_out is packed as {N,V,C,Z}
    localparam int FLAG_Z = 0;
    localparam int FLAG_C = 1;
    localparam int FLAG_V = 2;
    localparam int FLAG_N = 3;

endpackage

// File: rtl/alu_mc_if.sv
// Request/result bundle between a requester and alu_mc.
// Latency: n/a (wiring only).
// Backpressure: valid_in/ready_out on the request side, valid_out/ready_in on the result side.
interface alu_mc_if #(
    parameter int WIDTH = 8
) ();

    logic                 valid_in;
    logic                 ready_out;
    alu_mc_pkg::unit_e    unit_sel_in;
    logic                 op_sel_in;
    logic                 seg_sel_in;
    logic [WIDTH-1:0]     acc_in;
    logic [WIDTH-1:0]     src_in;
    logic [WIDTH-1:0]     res_out;
    logic [3:0]           flags_out;
    logic                 valid_out;
    logic                 ready_in;

    modport master (
        output valid_in, unit_sel_in, op_sel_in, seg_sel_in, acc_in, src_in, ready_in,
        input  ready_out, res_out, flags_out, valid_out
    );

    modport slave (
        input  valid_in, unit_sel_in, op_sel_in, seg_sel_in, acc_in, src_in, ready_in,
        output ready_out, res_out, flags_out, valid_out
    );

endinterface

// File: rtl/alu_mc_shift.sv
// Log-stage barrel shifter: left/right shift with zero fill, or rotate when rotate=1.
// Latency: combinational.
// Backpressure: none.
module alu_mc_shift #(
    parameter int WIDTH = 8,
    localparam int SHW  = $clog2(WIDTH)
) (
    input  logic [WIDTH-1:0] data,
    input  logic [SHW-1:0]   amt,
    input  logic             right,
    input  logic             rotate,
    output logic [WIDTH-1:0] result
);

    // stage[s] holds the value after amount bits [s-1:0] have been applied
    logic [WIDTH-1:0] stage [0:SHW];

    assign stage[0] = data;

    for (genvar s = 0; s < SHW; s++) begin : g_stage
        localparam int K = 1 << s;
        logic [WIDTH-1:0] shl, shr, rol, ror;

        assign shl = stage[s] << K;
        assign shr = stage[s] >> K;
        assign rol = shl | (stage[s] >> (WIDTH - K));
        assign ror = shr | (stage[s] << (WIDTH - K));

        assign stage[s+1] = !amt[s] ? stage[s] :
                            right   ? (rotate ? ror : shr) :
                                      (rotate ? rol : shl);
    end

    assign result = stage[SHW];

endmodule

// File: rtl/alu_mc.sv
// Multi-cycle ALU: add/sub, logic, barrel shift (rotate when ALU_MC_ROTATE_EN is defined), shift-add multiply.
// Latency: 1 cycle for non-mul units, WIDTH+1 cycles for mul.
// Backpressure: accepts only in IDLE; result held in DONE until ready_in, then one idle cycle before the next accept.
module alu_mc
    import alu_mc_pkg::*;
#(
    parameter int WIDTH = 8
) (
    input  logic   clk_in,
    input  logic   rst_in,
    alu_mc_if.slave bus
);

    localparam int SHW = $clog2(WIDTH);
    localparam logic [SHW-1:0] CNT_LAST = SHW'(WIDTH - 1);

    state_e state, state_nxt;
    logic   accept;

    logic [WIDTH-1:0] res_q;
    logic [3:0]       flags_q;

    // multiplier working registers
    logic [2*WIDTH-1:0] mcand, prod;
    logic [WIDTH-1:0]   mplier;
    logic [SHW-1:0]     cnt;
    logic               mul_neg, mul_hi;

    logic [2*WIDTH-1:0] prod_nxt, prod_fin;
    logic [WIDTH-1:0]   mul_res, acc_mag, src_mag;

    logic [WIDTH-1:0] addsub_b, shift_res, alu_res;
    logic [WIDTH:0]   addsub_sum;
    logic             alu_c, alu_v, shift_rot;
    logic [3:0]       alu_flags, mul_flags;

    assign accept        = (state == ST_IDLE) && bus.valid_in;
    assign bus.res_out   = res_q;
    assign bus.flags_out = flags_q;

`ifdef ALU_MC_ROTATE_EN
    assign shift_rot = bus.seg_sel_in;
`else
    assign shift_rot = 1'b0;
`endif

    alu_mc_shift #(.WIDTH(WIDTH)) u_shift (
        .data   (bus.acc_in),
        .amt    (bus.src_in[SHW-1:0]),
        .right  (bus.op_sel_in),
        .rotate (shift_rot),
        .result (shift_res)
    );

    // single-cycle units and their flags, evaluated directly on the request inputs
    always_comb begin
        addsub_b   = bus.op_sel_in ? ~bus.src_in : bus.src_in;
        addsub_sum = {1'b0, bus.acc_in} + {1'b0, addsub_b} + {{WIDTH{1'b0}}, bus.op_sel_in};
        alu_res    = '0;
        alu_c      = 1'b0;
        alu_v      = 1'b0;
        case (bus.unit_sel_in)
            UNIT_ADD: begin
                alu_res = addsub_sum[WIDTH-1:0];
                alu_c   = addsub_sum[WIDTH];
                alu_v   = (bus.acc_in[WIDTH-1] == addsub_b[WIDTH-1]) &&
                          (addsub_sum[WIDTH-1] != bus.acc_in[WIDTH-1]);
            end
            UNIT_SHIFT:    alu_res = shift_res;
            UNIT_PASS_SRC: alu_res = bus.src_in;
            UNIT_OR:       alu_res = bus.acc_in | bus.src_in;
            UNIT_XOR:      alu_res = bus.acc_in ^ bus.src_in;
            UNIT_AND:      alu_res = bus.acc_in & bus.src_in;
            UNIT_PASS_ACC: alu_res = bus.acc_in;
            default:       alu_res = '0;
        endcase
        alu_flags         = '0;
        alu_flags[FLAG_Z] = (alu_res == '0);
        alu_flags[FLAG_N] = alu_res[WIDTH-1];
        alu_flags[FLAG_C] = alu_c;
        alu_flags[FLAG_V] = alu_v;
    end

    // operand magnitudes for signed multiply, and the product as it will stand after this cycle's step
    always_comb begin
        acc_mag  = (bus.op_sel_in && bus.acc_in[WIDTH-1]) ? (~bus.acc_in + 1'b1) : bus.acc_in;
        src_mag  = (bus.op_sel_in && bus.src_in[WIDTH-1]) ? (~bus.src_in + 1'b1) : bus.src_in;
        prod_nxt = prod + (mplier[0] ? mcand : '0);
        prod_fin = mul_neg ? (~prod_nxt + 1'b1) : prod_nxt;
        mul_res  = mul_hi ? prod_fin[2*WIDTH-1:WIDTH] : prod_fin[WIDTH-1:0];
        mul_flags         = '0;
        mul_flags[FLAG_Z] = (mul_res == '0);
        mul_flags[FLAG_N] = mul_res[WIDTH-1];
    end

    // state register
    always_ff @(posedge clk_in or posedge rst_in) begin
        if (rst_in) state <= ST_IDLE;
        else        state <= state_nxt;
    end

    // next state and handshake outputs; the last multiply step also moves to DONE
    always_comb begin
        state_nxt     = state;
        bus.ready_out = 1'b0;
        bus.valid_out = 1'b0;
        case (state)
            ST_IDLE: begin
                bus.ready_out = 1'b1;
                if (bus.valid_in)
                    state_nxt = (bus.unit_sel_in == UNIT_MUL) ? ST_BUSY : ST_DONE;
            end
            ST_BUSY: if (cnt == CNT_LAST) state_nxt = ST_DONE;
            ST_DONE: begin
                bus.valid_out = 1'b1;
                if (bus.ready_in) state_nxt = ST_IDLE;
            end
            default: state_nxt = ST_IDLE;
        endcase
    end

    // result capture and shift-add multiplier stepping
    always_ff @(posedge clk_in or posedge rst_in) begin
        if (rst_in) begin
            res_q   <= '0;
            flags_q <= '0;
            mcand   <= '0;
            prod    <= '0;
            mplier  <= '0;
            cnt     <= '0;
            mul_neg <= 1'b0;
            mul_hi  <= 1'b0;
        end else begin
            if (accept) begin
                if (bus.unit_sel_in == UNIT_MUL) begin
                    mcand   <= {{WIDTH{1'b0}}, acc_mag};
                    mplier  <= src_mag;
                    prod    <= '0;
                    cnt     <= '0;
                    mul_neg <= bus.op_sel_in && (bus.acc_in[WIDTH-1] ^ bus.src_in[WIDTH-1]);
                    mul_hi  <= bus.seg_sel_in;
                end else begin
                    res_q   <= alu_res;
                    flags_q <= alu_flags;
                end
            end else if (state == ST_BUSY) begin
                prod   <= prod_nxt;
                mcand  <= mcand << 1;
                mplier <= mplier >> 1;
                cnt    <= cnt + 1'b1;
                if (cnt == CNT_LAST) begin
                    res_q   <= mul_res;
                    flags_q <= mul_flags;
                end
            end
        end
    end

endmodule
